mem_port_arbiter: RTL and testbench

//  Shares the single main_memory port between instruction fetch (ifu) and the

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_pick.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states and transaction owner.
package mem_port_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } mem_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-port signals of the arbiter, grouped as one bundle.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / BYTE_W;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [BE_W-1:0]   ls_be_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Priority select between fetch and load/store, with a starvation counter that
// forces a fetch win after STARVE_MAX consecutive losses.
module mem_port_arbiter_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_if_req,
  input  logic i_ls_req,
  input  logic i_port_free,
  output logic o_pick_if,
  output logic o_pick_ls
);
  localparam int unsigned ST_W = $clog2(STARVE_MAX + 1);

  logic [ST_W-1:0] r_starve;
  logic [ST_W-1:0] w_starve_nxt;
  logic            w_starved;

  assign w_starved = (r_starve == ST_W'(STARVE_MAX));

  // Load/store wins by default; a starved, still-requesting fetch overrides it.
  assign o_pick_if = !rst_i && i_port_free && i_if_req && (w_starved || !i_ls_req);
  assign o_pick_ls = !rst_i && i_port_free && i_ls_req && !(w_starved && i_if_req);

  always_comb begin
    w_starve_nxt = r_starve;
    if (o_pick_if || !i_if_req) begin
      w_starve_nxt = '0;
    end else if (o_pick_ls && !w_starved) begin
      w_starve_nxt = r_starve + ST_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: one transaction at a time,
// responses routed back to the owner MEM_LAT cycles after the command.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);
  localparam int unsigned BE_W  = DATA_W / BYTE_W;
  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

  arb_state_e        r_state, w_state_nxt;
  mem_owner_e        r_owner, w_owner_nxt;
  logic              r_we, w_we_nxt;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_cnt_nxt;

  logic              w_rvalid_cyc;
  logic              w_port_free;
  logic              w_pick_if;
  logic              w_pick_ls;
  logic              w_grant;
  logic              w_if_rvalid;
  logic              w_ls_rvalid;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;
  logic [BE_W-1:0]   w_cmd_be;

  // The response cycle also frees the port, allowing an overlapping grant.
  assign w_rvalid_cyc = !rst_i && (r_state == ARB_BUSY) && (r_lat_cnt == LAT_W'(1));
  assign w_port_free  = (r_state == ARB_IDLE) || w_rvalid_cyc;
  assign w_grant      = w_pick_if || w_pick_ls;

  mem_port_arbiter_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_if_req    (bus.if_req_i),
    .i_ls_req    (bus.ls_req_i),
    .i_port_free (w_port_free),
    .o_pick_if   (w_pick_if),
    .o_pick_ls   (w_pick_ls)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_NONE;
      r_we      <= 1'b0;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_we      <= w_we_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_we_nxt      = r_we;
    w_lat_cnt_nxt = (r_lat_cnt != '0) ? r_lat_cnt - LAT_W'(1) : r_lat_cnt;
    if (w_grant) begin
      w_state_nxt   = ARB_BUSY;
      w_owner_nxt   = w_pick_ls ? OWN_LS : OWN_IF;
      w_we_nxt      = w_pick_ls && bus.ls_we_i;
      w_lat_cnt_nxt = LAT_W'(MEM_LAT);
    end else if (w_rvalid_cyc) begin
      w_state_nxt = ARB_IDLE;
      w_owner_nxt = OWN_NONE;
      w_we_nxt    = 1'b0;
    end
  end

  // Command mux: the winner's fields drive the memory port, zeros otherwise.
  assign w_cmd_addr  = w_pick_ls ? bus.ls_addr_i : (w_pick_if ? bus.if_addr_i : '0);
  assign w_cmd_wdata = (w_pick_ls && bus.ls_we_i) ? bus.ls_wdata_i : '0;
  assign w_cmd_be    = w_pick_ls ? bus.ls_be_i : (w_pick_if ? '1 : '0);

  assign bus.if_gnt_o    = w_pick_if;
  assign bus.ls_gnt_o    = w_pick_ls;
  assign bus.mem_en_o    = w_grant;
  assign bus.mem_we_o    = w_pick_ls && bus.ls_we_i;
  assign bus.mem_addr_o  = w_cmd_addr;
  assign bus.mem_wdata_o = w_cmd_wdata;
  assign bus.mem_be_o    = w_cmd_be;

  // Response demux: store acks carry zero data.
  assign w_if_rvalid     = w_rvalid_cyc && (r_owner == OWN_IF);
  assign w_ls_rvalid     = w_rvalid_cyc && (r_owner == OWN_LS);
  assign bus.if_rvalid_o = w_if_rvalid;
  assign bus.ls_rvalid_o = w_ls_rvalid;
  assign bus.if_rdata_o  = w_if_rvalid ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = (w_ls_rvalid && !r_we) ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter at MEM_LAT = 1, 2 and 3.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int N_LAT      = 3;
  localparam int RUN_CYC    = 700;
  localparam int DRAIN_CYC  = 12;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  bit done [N_LAT];

  task automatic check(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL L%0d %s: got %h expected %h at %0t", lat, nm, act, exp, $time);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[4:2]);
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_1111);
  endfunction

  for (genvar g = 0; g < N_LAT; g++) begin : g_lat
    localparam int L = g + 1;

    logic        rst_i;
    logic [31:0] env_mem [8];
    logic [31:0] ref_mem [8];
    logic [31:0] pipe [L];
    exp_t        if_q [$];
    exp_t        ls_q [$];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MEM_LAT    (L),
      .STARVE_MAX (STARVE_MAX)
    ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
    );

    // Environment memory: driven purely by the mem_* port, read data delayed by L.
    assign bus.mem_rdata_i = pipe[L-1];
    always @(posedge clk_i) begin
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (bus.mem_en_o && !bus.mem_we_o) ? env_mem[widx(bus.mem_addr_o)] : $urandom;
      if (rst_i) begin
        for (int i = 0; i < 8; i++) env_mem[i] <= init_val(i);
      end else if (bus.mem_en_o && bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) env_mem[widx(bus.mem_addr_o)][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end
    end

    // Stimulus plus reference model: predicts grants and pushes expected responses.
    initial begin : drv
      int next_free, starve, rst_left, if_seq, pct_if, pct_ls;
      bit if_pend, ls_pend, lwe, want_rst, last_if_gnt, pk_if, pk_ls;
      logic [31:0] ia, la, lw, mask;
      logic [3:0]  lbe;
      exp_t        e;
      next_free = 0; starve = 0; rst_left = 2; if_seq = 0; pct_if = 0; pct_ls = 0;
      if_pend = 0; ls_pend = 0; lwe = 0; want_rst = 0; last_if_gnt = 0;
      ia = '0; la = '0; lw = '0; lbe = '0;
      rst_i = 1'b1;
      bus.if_req_i = 1'b0; bus.if_addr_i = '0;
      bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_addr_i = '0;
      bus.ls_wdata_i = '0; bus.ls_be_i = '0;
      for (int c = 0; c < RUN_CYC + DRAIN_CYC; c++) begin
        @(posedge clk_i); #1;
        // Reset lands one cycle after a fetch grant, while its response is in flight.
        if (c >= 250 && c < RUN_CYC && (c % 100) == 50) want_rst = 1;
        if (want_rst && last_if_gnt) begin rst_left = 2; want_rst = 0; end
        rst_i = (rst_left > 0);
        if (rst_left > 0) rst_left--;

        if (c < 60)            begin pct_if = 100; pct_ls = 0;   end
        else if (c < 200)      begin pct_if = 100; pct_ls = 100; end
        else if (c < RUN_CYC)  begin pct_if = 40;  pct_ls = 50;  end
        else                   begin pct_if = 0;   pct_ls = 0;   end

        if (!if_pend && int'($urandom_range(99)) < pct_if) begin
          if_pend = 1;
          ia = (c < 60) ? 32'(if_seq) : ($urandom & 32'h0000_0FFC);
          if_seq += 4;
        end else if (if_pend && pct_if < 100 && $urandom_range(15) == 0) begin
          if_pend = 0;
        end
        if (!ls_pend && int'($urandom_range(99)) < pct_ls) begin
          ls_pend = 1;
          lwe = 1'($urandom_range(1));
          la  = $urandom & 32'h0000_0FFC;
          lw  = $urandom;
          lbe = 4'($urandom);
        end else if (ls_pend && pct_ls < 100 && $urandom_range(15) == 0) begin
          ls_pend = 0;
        end
        bus.if_req_i = if_pend; bus.if_addr_i = ia;
        bus.ls_req_i = ls_pend; bus.ls_we_i = lwe; bus.ls_addr_i = la;
        bus.ls_wdata_i = lw; bus.ls_be_i = lbe;

        @(negedge clk_i);
        last_if_gnt = 0;
        if (rst_i) begin
          check(L, "rst if_gnt", bus.if_gnt_o, 1'b0);
          check(L, "rst ls_gnt", bus.ls_gnt_o, 1'b0);
          check(L, "rst mem_en", bus.mem_en_o, 1'b0);
          check(L, "rst mem_we", bus.mem_we_o, 1'b0);
          check(L, "rst mem_addr", bus.mem_addr_o, 32'h0);
          check(L, "rst mem_wdata", bus.mem_wdata_o, 32'h0);
          check(L, "rst mem_be", bus.mem_be_o, 4'h0);
          next_free = 0; starve = 0;
          for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
        end else begin
          pk_if = (cyc >= next_free) && if_pend && (starve == STARVE_MAX || !ls_pend);
          pk_ls = (cyc >= next_free) && ls_pend && !pk_if;
          check(L, "if_gnt", bus.if_gnt_o, pk_if);
          check(L, "ls_gnt", bus.ls_gnt_o, pk_ls);
          check(L, "mem_en", bus.mem_en_o, pk_if | pk_ls);
          if (pk_ls) begin
            check(L, "ls mem_we", bus.mem_we_o, lwe);
            check(L, "ls mem_addr", bus.mem_addr_o, la);
            check(L, "ls mem_be", bus.mem_be_o, lbe);
            e.due = cyc + L;
            if (lwe) begin
              check(L, "ls mem_wdata", bus.mem_wdata_o, lw);
              mask = {{8{lbe[3]}}, {8{lbe[2]}}, {8{lbe[1]}}, {8{lbe[0]}}};
              ref_mem[widx(la)] = (ref_mem[widx(la)] & ~mask) | (lw & mask);
              e.data = 32'h0;
            end else begin
              e.data = ref_mem[widx(la)];
            end
            ls_q.push_back(e);
          end else if (pk_if) begin
            check(L, "if mem_we", bus.mem_we_o, 1'b0);
            check(L, "if mem_addr", bus.mem_addr_o, ia);
            check(L, "if mem_be", bus.mem_be_o, 4'hF);
            e.due = cyc + L;
            e.data = ref_mem[widx(ia)];
            if_q.push_back(e);
          end else begin
            check(L, "idle mem_we", bus.mem_we_o, 1'b0);
          end
          if (pk_if || pk_ls) next_free = cyc + L;
          if (pk_if || !if_pend) starve = 0;
          else if (pk_ls && starve < STARVE_MAX) starve++;
          if (pk_if) begin if_pend = 0; last_if_gnt = 1; end
          if (pk_ls) ls_pend = 0;
        end
      end
      check(L, "drain outstanding", 32'(if_q.size() + ls_q.size()), 32'h0);
      done[g] = 1;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk_i);
        if (rst_i) begin
          check(L, "rst if_rvalid", bus.if_rvalid_o, 1'b0);
          check(L, "rst ls_rvalid", bus.ls_rvalid_o, 1'b0);
          check(L, "rst if_rdata", bus.if_rdata_o, 32'h0);
          check(L, "rst ls_rdata", bus.ls_rdata_o, 32'h0);
          if_q.delete();
          ls_q.delete();
        end else begin
          if (bus.if_rvalid_o) begin
            if (if_q.size() == 0) check(L, "if_rvalid unexpected", bus.if_rvalid_o, 1'b0);
            else begin
              e = if_q.pop_front();
              check(L, "if_rvalid cycle", 32'(cyc), 32'(e.due));
              check(L, "if_rdata", bus.if_rdata_o, e.data);
            end
          end else begin
            check(L, "if_rdata idle", bus.if_rdata_o, 32'h0);
            if (if_q.size() > 0 && if_q[0].due <= cyc) begin
              check(L, "if_rvalid missing", bus.if_rvalid_o, 1'b1);
              e = if_q.pop_front();
            end
          end
          if (bus.ls_rvalid_o) begin
            if (ls_q.size() == 0) check(L, "ls_rvalid unexpected", bus.ls_rvalid_o, 1'b0);
            else begin
              e = ls_q.pop_front();
              check(L, "ls_rvalid cycle", 32'(cyc), 32'(e.due));
              check(L, "ls_rdata", bus.ls_rdata_o, e.data);
            end
          end else begin
            check(L, "ls_rdata idle", bus.ls_rdata_o, 32'h0);
            if (ls_q.size() > 0 && ls_q[0].due <= cyc) begin
              check(L, "ls_rvalid missing", bus.ls_rvalid_o, 1'b1);
              e = ls_q.pop_front();
            end
          end
          check(L, "rvalid overlap", bus.if_rvalid_o & bus.ls_rvalid_o, 1'b0);
        end
      end
    end
  end

  initial begin : finish_ctl
    int  t;
    bit  all_done;
    t = 0;
    all_done = 0;
    while (!all_done && t < 3000) begin
      @(posedge clk_i);
      t++;
      all_done = 1;
      for (int i = 0; i < N_LAT; i++) if (!done[i]) all_done = 0;
    end
    if (!all_done) begin
      n_total++;
      $display("FAIL run timeout: stimulus did not complete within %0d cycles", t);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
